// File: rtl/mult_iter_param.sv
// Iterative shift-add multiplier, one multiplier bit per cycle, optional early exit.
// Latency n+1 cycles from accept to mult_end; begin is ignored while busy (no queueing).
module mult_iter_param #(
    parameter int WIDTH      = 32,
    parameter int EARLY_EXIT = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               mult_begin,
    input  logic               mult_signed,
    input  logic [WIDTH-1:0]   mult_op1,
    input  logic [WIDTH-1:0]   mult_op2,
    output logic [2*WIDTH-1:0] product,
    output logic               mult_end,
    output logic               mult_busy
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state_q, state_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] product_q, product_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               neg_q, neg_d;
    logic [WIDTH-1:0]   mag1, mag2;
    logic               calc_last;

    always_comb begin
        mag1 = (mult_signed && mult_op1[WIDTH-1]) ? -mult_op1 : mult_op1;
        mag2 = (mult_signed && mult_op2[WIDTH-1]) ? -mult_op2 : mult_op2;
        // cnt_q != 0 guarantees at least one iteration even when op2 is zero
        calc_last = (cnt_q == CW'(WIDTH)) ||
                    ((EARLY_EXIT != 0) && (cnt_q != '0) && (mplier_q == '0));
    end

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        product_d = product_q;
        mplier_d  = mplier_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        case (state_q)
            IDLE: begin
                if (mult_begin) begin
                    state_d  = CALC;
                    mcand_d  = {{WIDTH{1'b0}}, mag1};
                    mplier_d = mag2;
                    acc_d    = '0;
                    cnt_d    = '0;
                    neg_d    = mult_signed & (mult_op1[WIDTH-1] ^ mult_op2[WIDTH-1]);
                end
            end
            CALC: begin
                if (calc_last) begin
                    state_d   = DONE;
                    product_d = neg_q ? -acc_q : acc_q;
                end else begin
                    if (mplier_q[0]) begin
                        acc_d = acc_q + mcand_q;
                    end
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + CW'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            acc_q     <= '0;
            product_q <= '0;
            mplier_q  <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            acc_q     <= acc_d;
            product_q <= product_d;
            mplier_q  <= mplier_d;
            cnt_q     <= cnt_d;
            neg_q     <= neg_d;
        end
    end

    assign product   = product_q;
    assign mult_end  = (state_q == DONE);
    assign mult_busy = (state_q != IDLE);

endmodule

// File: tb/tb_mult_iter_param.sv
// Fixed-latency and early-exit instances run side by side on the same operations.
module tb_mult_iter_param;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mult_begin = 1'b0;
    logic        mult_signed = 1'b0;
    logic [31:0] mult_op1 = '0;
    logic [31:0] mult_op2 = '0;
    logic [63:0] prod_a, prod_b;
    logic        end_a, end_b, busy_a, busy_b;

    typedef struct {
        logic [63:0] prod;
        int          end_cyc;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mult_iter_param #(.WIDTH(32), .EARLY_EXIT(0)) dut_a (
        .clk(clk), .reset(reset), .mult_begin(mult_begin), .mult_signed(mult_signed),
        .mult_op1(mult_op1), .mult_op2(mult_op2),
        .product(prod_a), .mult_end(end_a), .mult_busy(busy_a)
    );

    mult_iter_param #(.WIDTH(32), .EARLY_EXIT(1)) dut_b (
        .clk(clk), .reset(reset), .mult_begin(mult_begin), .mult_signed(mult_signed),
        .mult_op1(mult_op1), .mult_op2(mult_op2),
        .product(prod_b), .mult_end(end_b), .mult_busy(busy_b)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Monitor: every mult_end must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (end_a) begin
            if (qa.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL a_extra_end: got mult_end at cycle %0d expected none", cyc);
            end else begin
                ea = qa.pop_front();
                chk("a_product", prod_a, ea.prod);
                chk("a_end_cycle", 64'(cyc), 64'(ea.end_cyc));
            end
        end
        if (end_b) begin
            if (qb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_extra_end: got mult_end at cycle %0d expected none", cyc);
            end else begin
                eb = qb.pop_front();
                chk("b_product", prod_b, eb.prod);
                chk("b_end_cycle", 64'(cyc), 64'(eb.end_cyc));
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while ((busy_a || busy_b) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 300) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: got busy after %0d cycles expected idle", n);
        end
    endtask

    // lat_b is the hand-computed early-exit latency (iterations + 1)
    task automatic do_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input int lat_b);
        exp_t e;
        wait_idle();
        @(negedge clk);
        mult_signed = sgn;
        mult_op1    = a;
        mult_op2    = b;
        mult_begin  = 1'b1;
        @(posedge clk);
        #1;
        mult_begin = 1'b0;
        e.prod = exp;
        e.end_cyc = cyc + 33;
        qa.push_back(e);
        e.end_cyc = cyc + lat_b;
        qb.push_back(e);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_prod_a", prod_a, 64'h0);
        chk("reset_prod_b", prod_b, 64'h0);
        chk("reset_end_a", {63'h0, end_a}, 64'h0);
        chk("reset_end_b", {63'h0, end_b}, 64'h0);
        chk("reset_busy_a", {63'h0, busy_a}, 64'h0);
        chk("reset_busy_b", {63'h0, busy_b}, 64'h0);
        @(negedge clk);
        reset = 1'b0;

        do_op(1'b0, 32'h0000_1111, 32'h0000_1111, 64'h0000_0000_0123_4321, 14);
        wait_idle();
        repeat (4) @(posedge clk);
        #1;
        chk("hold_prod_a", prod_a, 64'h0000_0000_0123_4321);
        chk("hold_prod_b", prod_b, 64'h0000_0000_0123_4321);

        do_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 33);
        do_op(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, 2);
        do_op(1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 33);
        do_op(1'b1, 32'hFFFF_FFFD, 32'h0000_0005, 64'hFFFF_FFFF_FFFF_FFF1, 4);
        do_op(1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFF2, 3);
        do_op(1'b0, 32'h0000_0007, 32'h0000_0001, 64'h0000_0000_0000_0007, 2);
        do_op(1'b0, 32'h0000_0003, 32'h8000_0000, 64'h0000_0001_8000_0000, 33);
        do_op(1'b0, 32'h1234_5678, 32'h0000_0000, 64'h0, 2);
        do_op(1'b1, 32'hFFFF_FFFB, 32'h0000_0000, 64'h0, 2);

        // A second begin mid-operation must be dropped
        do_op(1'b0, 32'hFFFF_FFFF, 32'h8000_0000, 64'h7FFF_FFFF_8000_0000, 33);
        repeat (8) @(posedge clk);
        @(negedge clk);
        mult_signed = 1'b0;
        mult_op1    = 32'd3;
        mult_op2    = 32'd5;
        mult_begin  = 1'b1;
        @(posedge clk);
        #1;
        mult_begin = 1'b0;
        chk("ignored_begin_busy_a", {63'h0, busy_a}, 64'h1);
        chk("ignored_begin_busy_b", {63'h0, busy_b}, 64'h1);

        // Reset in the middle of CALC discards the operation
        do_op(1'b0, 32'hFFFF_FFFF, 32'h8000_0000, 64'h7FFF_FFFF_8000_0000, 33);
        repeat (9) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        qa.delete();
        qb.delete();
        chk("midreset_busy_a", {63'h0, busy_a}, 64'h0);
        chk("midreset_busy_b", {63'h0, busy_b}, 64'h0);
        chk("midreset_prod_a", prod_a, 64'h0);
        chk("midreset_prod_b", prod_b, 64'h0);
        chk("midreset_end_a", {63'h0, end_a}, 64'h0);
        @(negedge clk);
        reset = 1'b0;
        do_op(1'b1, 32'hFFFF_FFFD, 32'h0000_0005, 64'hFFFF_FFFF_FFFF_FFF1, 4);

        wait_idle();
        repeat (3) @(posedge clk);
        #1;
        chk("pending_a", 64'(qa.size()), 64'h0);
        chk("pending_b", 64'(qb.size()), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
